// File: rtl/dma_fifo_rd_ctrl.sv
// dma_fifo_rd_ctrl: pointer/flow controller for the DMA channel's synchronous-read
// cache RAM. Pushes write straight into the RAM. Reads are issued against a 4-entry
// credit and land in a skid buffer that absorbs the fixed RAM read latency, so the
// pop side sees a bubble-free valid/ready stream.
// Optional build macro: DMA_FIFO_ECC_STATUS_EN (sticky ECC status flags plus
// a per-entry double-bit tag in the skid buffer).
module dma_fifo_rd_ctrl #(
    parameter int WIDTH  = 128,
    parameter int AW     = 7,
    parameter int RD_LAT = 2    // legal 1..3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data,
    output logic [AW+1:0]    level,
    output logic             ram_wen,
    output logic [AW-1:0]    ram_waddr,
    output logic [WIDTH-1:0] ram_wdata,
    output logic             ram_ren,
    output logic [AW-1:0]    ram_raddr,
    input  logic [WIDTH-1:0] ram_rdata,
    input  logic             ram_sb_correct,
    input  logic             ram_db_detect,
    output logic             err_sb,
    output logic             err_db
);

    localparam int          LW      = AW + 2;
    localparam logic [AW:0] DEPTH   = (AW + 1)'(1 << AW);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    // RAM pointers carry one extra bit so full and empty are distinguishable.
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic [AW:0]        ram_cnt;

    // Reads issued but not yet returned, and words sitting in the skid buffer.
    logic [2:0]         inflight;
    logic [2:0]         skid_cnt;
    logic [1:0]         skid_wr;
    logic [1:0]         skid_rd;
    logic [WIDTH-1:0]   skid_mem [4];

    // One bit per RAM pipeline stage; the tail marks a read returning this cycle.
    logic [RD_LAT-1:0]  vld_sr;

    logic               push;
    logic               issue;
    logic               pop;
    logic               ret;

    assign ram_cnt    = wr_ptr - rd_ptr;
    assign push_ready = (ram_cnt != DEPTH);
    assign pop_valid  = (skid_cnt != 3'd0);
    assign pop_data   = skid_mem[skid_rd];

    // Credit rule: a read is only issued if its word is guaranteed a skid slot,
    // so returns never need to be throttled or dropped.
    assign push  = push_valid & push_ready & ~flush;
    assign issue = (ram_cnt != '0) & (({1'b0, inflight} + {1'b0, skid_cnt}) < 4'd4) & ~flush;
    assign pop   = pop_valid & pop_ready;
    assign ret   = vld_sr[RD_LAT-1];

    assign ram_wen   = push;
    assign ram_waddr = wr_ptr[AW-1:0];
    assign ram_wdata = push_data;
    assign ram_ren   = issue;
    assign ram_raddr = rd_ptr[AW-1:0];

    assign level = LW'(ram_cnt) + LW'(inflight) + LW'(skid_cnt);

    // Pointer, credit and return-pipeline state; flush outranks every other update.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= 3'd0;
            skid_cnt <= 3'd0;
            skid_wr  <= 2'd0;
            skid_rd  <= 2'd0;
            vld_sr   <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= 3'd0;
            skid_cnt <= 3'd0;
            skid_wr  <= 2'd0;
            skid_rd  <= 2'd0;
            vld_sr   <= '0;
        end else begin
            if (push)  wr_ptr  <= wr_ptr + PTR_ONE;
            if (issue) rd_ptr  <= rd_ptr + PTR_ONE;
            if (ret)   skid_wr <= skid_wr + 2'd1;
            if (pop)   skid_rd <= skid_rd + 2'd1;
            vld_sr <= RD_LAT'({vld_sr, issue});
            case ({issue, ret})
                2'b10:   inflight <= inflight + 3'd1;
                2'b01:   inflight <= inflight - 3'd1;
                default: inflight <= inflight;
            endcase
            case ({ret, pop})
                2'b10:   skid_cnt <= skid_cnt + 3'd1;
                2'b01:   skid_cnt <= skid_cnt - 3'd1;
                default: skid_cnt <= skid_cnt;
            endcase
        end
    end

    // Skid data capture on every RAM return.
    always_ff @(posedge clock) begin
        // NOTE: storage arrays carry no reset; the occupancy count alone says
        // which entries hold live data.
        if (ret) skid_mem[skid_wr] <= ram_rdata;
    end

`ifdef DMA_FIFO_ECC_STATUS_EN
    logic       sb_flag;
    logic       db_flag;
    logic [3:0] skid_db_tag;
    logic       unused_tag;

    // Sticky ECC status, collected only from returns that reach the skid buffer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sb_flag <= 1'b0;
            db_flag <= 1'b0;
        end else if (flush) begin
            sb_flag <= 1'b0;
            db_flag <= 1'b0;
        end else if (ret) begin
            sb_flag <= sb_flag | ram_sb_correct;
            db_flag <= db_flag | ram_db_detect;
        end
    end

    // Double-bit tag travels with its word through the skid buffer.
    always_ff @(posedge clock) begin
        if (ret) skid_db_tag[skid_wr] <= ram_db_detect;
    end

    assign err_sb     = sb_flag;
    assign err_db     = db_flag;
    assign unused_tag = skid_db_tag[skid_rd];
`else
    logic unused_ecc;

    assign err_sb     = 1'b0;
    assign err_db     = 1'b0;
    assign unused_ecc = ram_sb_correct ^ ram_db_detect;
`endif

endmodule

// File: tb/tb_dma_fifo_rd_ctrl.sv
// tb_dma_fifo_rd_ctrl: directed + randomized bench for dma_fifo_rd_ctrl with a
// behavioural RAM, a data scoreboard and a count-based occupancy model.
// Honours DMA_FIFO_ECC_STATUS_EN for the expected ECC flag values.
module tb_dma_fifo_rd_ctrl;

    localparam int W      = 128;
    localparam int AW     = 7;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = 1 << AW;
    localparam int LW     = AW + 2;

`ifdef DMA_FIFO_ECC_STATUS_EN
    localparam bit ECC_ON = 1'b1;
`else
    localparam bit ECC_ON = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset_n;
    logic          flush;
    logic          push_valid;
    logic          push_ready;
    logic [W-1:0]  push_data;
    logic          pop_valid;
    logic          pop_ready;
    logic [W-1:0]  pop_data;
    logic [LW-1:0] level;
    logic          ram_wen;
    logic [AW-1:0] ram_waddr;
    logic [W-1:0]  ram_wdata;
    logic          ram_ren;
    logic [AW-1:0] ram_raddr;
    logic [W-1:0]  ram_rdata;
    logic          ram_sb_correct;
    logic          ram_db_detect;
    logic          err_sb;
    logic          err_db;

    always #5 clock = ~clock;

    dma_fifo_rd_ctrl #(.WIDTH(W), .AW(AW), .RD_LAT(RD_LAT)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .flush          (flush),
        .push_valid     (push_valid),
        .push_ready     (push_ready),
        .push_data      (push_data),
        .pop_valid      (pop_valid),
        .pop_ready      (pop_ready),
        .pop_data       (pop_data),
        .level          (level),
        .ram_wen        (ram_wen),
        .ram_waddr      (ram_waddr),
        .ram_wdata      (ram_wdata),
        .ram_ren        (ram_ren),
        .ram_raddr      (ram_raddr),
        .ram_rdata      (ram_rdata),
        .ram_sb_correct (ram_sb_correct),
        .ram_db_detect  (ram_db_detect),
        .err_sb         (err_sb),
        .err_db         (err_db)
    );

    // Behavioural synchronous-read RAM with RD_LAT cycles of read latency and
    // ECC status injected on chosen read sequence numbers.
    logic [W-1:0] mem     [DEPTH];
    logic [W-1:0] rd_pipe [RD_LAT];
    logic         sb_pipe [RD_LAT] = '{default: 1'b0};
    logic         db_pipe [RD_LAT] = '{default: 1'b0};
    int           ren_seq   = 0;
    int           sb_target = -1;
    int           db_target = -1;

    always @(posedge clock) begin
        if (ram_wen) mem[ram_waddr] <= ram_wdata;
        rd_pipe[0] <= mem[ram_raddr];
        sb_pipe[0] <= ram_ren && (ren_seq == sb_target);
        db_pipe[0] <= ram_ren && (ren_seq == db_target);
        for (int i = 1; i < RD_LAT; i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
            sb_pipe[i] <= sb_pipe[i-1];
            db_pipe[i] <= db_pipe[i-1];
        end
        if (ram_ren) ren_seq <= ren_seq + 1;
    end

    assign ram_rdata      = rd_pipe[RD_LAT-1];
    assign ram_sb_correct = sb_pipe[RD_LAT-1];
    assign ram_db_detect  = db_pipe[RD_LAT-1];

    // Reference model: expected data order, total words held, and reads issued
    // but not yet consumed (in flight plus skid).
    logic [W-1:0]  exp_q [$];
    int            total = 0;
    int            bad   = 0;
    int            model_level;
    int            outstanding;
    int            wr_cnt;
    int            rd_cnt;
    bit            exp_sb;
    bit            exp_db;

    bit            obs_ren;
    bit            obs_pv;
    bit            obs_pr;
    logic [W-1:0]  obs_pd;
    logic [AW-1:0] obs_raddr;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        model_level = 0;
        outstanding = 0;
        wr_cnt      = 0;
        rd_cnt      = 0;
        exp_sb      = 1'b0;
        exp_db      = 1'b0;
    endtask

    function automatic logic [W-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock cycle: drive, observe at the falling edge, update the model.
    task automatic step(input bit pv, input logic [W-1:0] pd, input bit pr, input bit fl);
        bit push_acc;
        bit pop_acc;
        int ram_words;
        push_valid = pv;
        push_data  = pd;
        pop_ready  = pr;
        flush      = fl;
        @(negedge clock);
        obs_ren   = ram_ren;
        obs_raddr = ram_raddr;
        obs_pv    = pop_valid;
        obs_pd    = pop_data;
        obs_pr    = push_ready;
        check("err_sb", err_sb, ECC_ON & exp_sb);
        check("err_db", err_db, ECC_ON & exp_db);
        if (fl) begin
            check("flush_wen", ram_wen, 0);
            check("flush_ren", ram_ren, 0);
            clear_model();
        end else begin
            ram_words = model_level - outstanding;
            push_acc  = pv && push_ready;
            pop_acc   = pop_valid && pr;
            check("level", level, model_level);
            check("push_ready", push_ready, ram_words != DEPTH);
            check("ren", ram_ren, (ram_words > 0) && (outstanding < 4));
            check("wen", ram_wen, push_acc);
            if (push_acc) begin
                check("waddr", ram_waddr, wr_cnt % DEPTH);
                check("wdata", ram_wdata, pd);
            end
            if (ram_ren) check("raddr", ram_raddr, rd_cnt % DEPTH);
            if (pop_acc) begin
                if (exp_q.size() == 0) check("pop_extra", 1, 0);
                else check("pop_data", pop_data, exp_q.pop_front());
            end
            if (push_acc) begin
                exp_q.push_back(pd);
                model_level++;
                wr_cnt++;
            end
            if (ram_ren) begin
                rd_cnt++;
                outstanding++;
            end
            if (pop_acc) begin
                model_level--;
                outstanding--;
            end
            check("credit", outstanding <= 4, 1);
            if (ram_sb_correct === 1'b1) exp_sb = 1'b1;
            if (ram_db_detect === 1'b1) exp_db = 1'b1;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        flush      = 1'b0;
        push_data  = '0;
        reset_n    = 1'b0;
        #1;
        check("rst_push_ready", push_ready, 1);
        check("rst_pop_valid", pop_valid, 0);
        check("rst_level", level, 0);
        check("rst_wen", ram_wen, 0);
        check("rst_ren", ram_ren, 0);
        check("rst_err_sb", err_sb, 0);
        check("rst_err_db", err_db, 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        clear_model();
    endtask

    // Run with both sides open until the scoreboard is empty or the budget ends.
    task automatic drain(input string tag);
        for (int c = 0; c < 300 && exp_q.size() != 0; c++) step(0, '0, 1, 0);
        check(tag, exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int  acc;
        int  sent;
        bit  prev_ren;
        bit  seen;

        // Reset values from power-up.
        clear_model();
        do_reset();

        // Latency: push at cycle 0, read issued at 1, data visible at 2+RD_LAT.
        step(1, W'(8'hA5), 0, 0);
        step(0, '0, 0, 0);
        check("lat_ren_c1", obs_ren, 1);
        check("lat_raddr_c1", obs_raddr, 0);
        step(0, '0, 0, 0);
        check("lat_pv_c2", obs_pv, 0);
        step(0, '0, 0, 0);
        check("lat_pv_c3", obs_pv, 0);
        step(0, '0, 0, 0);
        check("lat_pv_c4", obs_pv, 1);
        check("lat_pd_c4", obs_pd, W'(8'hA5));
        step(0, '0, 1, 0);
        step(0, '0, 0, 0);
        check("lat_drained", exp_q.size(), 0);

        // Reset mid-stream with 37 words held.
        for (int i = 0; i < 37; i++) step(1, rand_word(), 0, 0);
        step(0, '0, 0, 0);
        check("pre_rst_level", level, 37);
        do_reset();
        step(0, '0, 0, 0);
        check("post_rst_pv", obs_pv, 0);
        check("post_rst_level", level, 0);

        // Fill: 128 pushes, then keep pushing until full. Four words drain into
        // the skid buffer, so capacity is the RAM depth plus four.
        for (int i = 0; i < DEPTH; i++) step(1, rand_word(), 0, 0);
        check("fill_level_128", level, DEPTH);
        acc = DEPTH;
        for (int i = 0; i < 10; i++) begin
            step(1, rand_word(), 0, 0);
            if (obs_pr) acc++;
        end
        check("fill_accepted", acc, DEPTH + 4);
        check("fill_push_ready", push_ready, 0);
        check("fill_level_full", level, DEPTH + 4);

        // Stream 300 more words with both sides active; addresses wrap.
        sent = 0;
        for (int c = 0; c < 2000 && (sent < 300 || exp_q.size() != 0); c++) begin
            step(sent < 300, rand_word(), 1, 0);
            if (sent < 300 && obs_pr) sent++;
        end
        check("stream_sent", sent, 300);
        check("stream_drained", exp_q.size(), 0);
        check("stream_wrapped", wr_cnt > DEPTH, 1);

        // Random backpressure: 30% of cycles refuse pops.
        for (int c = 0; c < 600; c++)
            step($urandom_range(0, 9) < 6, rand_word(), $urandom_range(0, 9) >= 3, 0);
        drain("bp_drained");

        // Flush with two reads in flight; stale returns must be discarded.
        prev_ren = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step(1, rand_word(), 1, 0);
            if (prev_ren && obs_ren) break;
            prev_ren = obs_ren;
        end
        check("flush_two_inflight", prev_ren && obs_ren, 1);
        step(0, '0, 1, 1);
        step(0, '0, 1, 0);
        check("flush_pv", obs_pv, 0);
        check("flush_level", level, 0);
        step(1, W'(1), 1, 0);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            step(0, '0, 1, 0);
            if (obs_pv) begin
                seen = 1'b1;
                check("flush_first_word", obs_pd, W'(1));
            end
        end
        check("flush_word_seen", seen, 1);

        // ECC: single-bit on the 2nd return, double-bit on the 5th.
        sb_target = ren_seq + 1;
        db_target = ren_seq + 4;
        for (int i = 0; i < 8; i++) step(1, rand_word(), 1, 0);
        drain("ecc_drained");
        check("ecc_db_sticky", err_db, ECC_ON);
        check("ecc_sb_sticky", err_sb, ECC_ON);
        sb_target = -1;
        db_target = -1;
        step(0, '0, 0, 1);
        step(0, '0, 0, 0);
        check("ecc_db_cleared", err_db, 0);
        check("ecc_sb_cleared", err_sb, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
